serial_out_tx: RTL

- Transmit end of the MSDAP serial audio interface: the counterpart of the serial-input/frame-capture path.
- Accepts one computed stereo output sample (left and right, WIDTH bits each) over a valid/ready handshake and buffers it in a one-entry holding register.
- On the next frame pulse (already synchronised into the clk domain), shifts the sample out MSB-first on OutputL/OutputR, one bit per bit_en strobe, with OutReady framing the transfer.

---
 rtl/msdap_pkg.sv | 11 +
 rtl/serial_out_tx_if.sv | 23 ++
 rtl/tx_shift_reg.sv | 29 ++
 rtl/serial_out_tx.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/msdap_pkg.sv
// Shared MSDAP definitions: output word width and transmit FSM states.
package msdap_pkg;

  localparam int OUT_WIDTH = 40;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

endpackage

// File: rtl/serial_out_tx_if.sv
// Sample handshake between the output-sample producer and the serial transmitter.
interface serial_out_tx_if #(
  parameter int WIDTH = msdap_pkg::OUT_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] in_dataL;
  logic [WIDTH-1:0] in_dataR;
  logic             in_ready;

  modport master (
    output in_valid,
    output in_dataL,
    output in_dataR,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_dataL,
    input  in_dataR,
    output in_ready
  );
endinterface

// File: rtl/tx_shift_reg.sv
// Parallel-load, enable-shift register presenting its MSB as the serial bit.
// Zeros are shifted in, so a fully shifted word leaves the line at 0.
module tx_shift_reg #(
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] data_reg;

  // Load has priority over shift; the FSM never asserts both together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= din;
    end else if (shift) begin
      data_reg <= {data_reg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = data_reg[WIDTH-1];

endmodule

// File: rtl/serial_out_tx.sv
// MSDAP serial transmitter: one-entry holding register for a stereo sample,
// moved into L/R shifters on a frame pulse and sent MSB-first per bit_en.
module serial_out_tx
  import msdap_pkg::*;
#(
  parameter int WIDTH = OUT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_pulse,
  input  logic                  bit_en,
  serial_out_tx_if.slave        bus,
  input  logic                  err_clr,
  output logic                  OutputL,
  output logic                  OutputR,
  output logic                  OutReady,
  output logic                  word_done,
  output logic                  underrun,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  tx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             hold_full_reg, hold_full_next;
  logic [WIDTH-1:0] holdL_reg, holdR_reg;
  logic             word_done_reg, word_done_next;
  logic             underrun_reg, underrun_next;
  logic             overrun_reg, overrun_next;
  logic             accept;
  logic             load_en;
  logic             shift_en;

  logic [1:0][WIDTH-1:0] hold_word;
  logic [1:0]            serial_bit;

  assign bus.in_ready = ~hold_full_reg;
  assign accept       = bus.in_valid & ~hold_full_reg;

  // State, counter, holding flag and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      hold_full_reg <= 1'b0;
      word_done_reg <= 1'b0;
      underrun_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      hold_full_reg <= hold_full_next;
      word_done_reg <= word_done_next;
      underrun_reg  <= underrun_next;
      overrun_reg   <= overrun_next;
    end
  end

  // Capture the offered sample when the holding register is empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      holdL_reg <= '0;
      holdR_reg <= '0;
    end else if (accept) begin
      holdL_reg <= bus.in_dataL;
      holdR_reg <= bus.in_dataR;
    end
  end

  // Next-state logic: frame handling, bit counting and sticky errors (set wins over clear).
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    hold_full_next = hold_full_reg;
    word_done_next = 1'b0;
    underrun_next  = underrun_reg & ~err_clr;
    overrun_next   = overrun_reg & ~err_clr;
    load_en        = 1'b0;
    shift_en       = 1'b0;

    // Accept only happens while empty, and load only while full, so they never collide.
    if (accept) begin
      hold_full_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (frame_pulse) begin
          if (hold_full_reg) begin
            load_en        = 1'b1;
            hold_full_next = 1'b0;
            cnt_next       = '0;
            state_next     = SHIFT;
          end else begin
            underrun_next = 1'b1;
          end
        end
      end
      SHIFT: begin
        // A frame mid-word is flagged and otherwise ignored.
        if (frame_pulse) begin
          overrun_next = 1'b1;
        end
        if (bit_en) begin
          shift_en = 1'b1;
          if (cnt_reg == LAST_BIT) begin
            cnt_next       = '0;
            state_next     = IDLE;
            word_done_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign hold_word = {holdR_reg, holdL_reg};

  // Lane 0 carries the left channel, lane 1 the right channel.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      tx_shift_reg #(
        .WIDTH(WIDTH)
      ) u_shift (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_en),
        .shift   (shift_en),
        .din     (hold_word[gi]),
        .msb     (serial_bit[gi])
      );
    end
  endgenerate

  assign OutputL   = serial_bit[0];
  assign OutputR   = serial_bit[1];
  assign OutReady  = (state_reg == SHIFT);
  assign word_done = word_done_reg;
  assign underrun  = underrun_reg;
  assign overrun   = overrun_reg;

endmodule
